// File: rtl/bus_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin datapath bus arbiter.
// Imported by bus_arbiter and rr_priority_pick.
package bus_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_HOLD   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } bus_state_e;

  // Index of the set bit in a one-hot vector (up to 16 requesters); zero when none set.
  function automatic int onehot_to_idx(input logic [15:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate requests so the slot after last_owner
// sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_priority_pick
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  localparam int SEL_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SEL_WIDTH-1:0] last_owner,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] winner
);

  logic [NUM_REQ-1:0] rotated;
  int                 start;
  int                 offset;

  // NOTE: combinational logic uses blocking assignments and gives every output a
  // default before any branch, so no path leaves a value held (no latch).
  always_comb begin
    start   = (int'(last_owner) + 1) % NUM_REQ;
    rotated = '0;
    offset  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated[i] = req[(i + start) % NUM_REQ];
    end
    // Descending scan: the last hit written is the lowest set bit.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = i;
    end
    found  = |req;
    winner = SEL_WIDTH'((offset + start) % NUM_REQ);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal datapath bus: one-hot grant plus encoded mux
// select, one dead turnaround cycle between owners, and a hold limit against starvation.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_HOLD   = DEF_MAX_HOLD,
  localparam int SEL_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic [SEL_WIDTH-1:0]          grant_sel,
  output logic [DATA_WIDTH-1:0]         bus_out,
  output logic                          bus_valid,
  output logic                          timeout
);

  localparam int HOLD_WIDTH = $clog2(MAX_HOLD);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LIMIT = HOLD_WIDTH'(MAX_HOLD - 1);

  bus_state_e            state, state_next;
  logic [NUM_REQ-1:0]    grant_next;
  logic [SEL_WIDTH-1:0]  grant_sel_next;
  logic [SEL_WIDTH-1:0]  last_owner, last_owner_next;
  logic [HOLD_WIDTH-1:0] hold_cnt, hold_cnt_next;
  logic                  timeout_next;

  logic                  found;
  logic [SEL_WIDTH-1:0]  winner;
  logic                  owner_req;
  logic                  others_req;
  logic [DATA_WIDTH-1:0] src [NUM_REQ];

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .found      (found),
    .winner     (winner)
  );

  // grant is one-hot on the owner while in GRANT, so masking req with it
  // separates the owner's request from everyone else's.
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    grant_sel_next  = grant_sel;
    last_owner_next = last_owner;
    hold_cnt_next   = hold_cnt;
    timeout_next    = 1'b0;

    unique case (state)
      IDLE, TURN: begin
        if (found) begin
          state_next      = GRANT;
          grant_next      = NUM_REQ'(1) << winner;
          grant_sel_next  = SEL_WIDTH'(onehot_to_idx(16'(grant_next)));
          last_owner_next = winner;
          hold_cnt_next   = '0;
        end else begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_next = TURN;
          grant_next = '0;
        end else if (hold_cnt == HOLD_LIMIT && others_req) begin
          state_next   = TURN;
          grant_next   = '0;
          timeout_next = 1'b1;
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_cnt_next = hold_cnt + HOLD_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      grant_sel  <= '0;
      last_owner <= SEL_WIDTH'(NUM_REQ - 1);
      hold_cnt   <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      grant_sel  <= grant_sel_next;
      last_owner <= last_owner_next;
      hold_cnt   <= hold_cnt_next;
      timeout    <= timeout_next;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Bus data trails grant by one cycle; the owner's source is resampled every cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
    end else begin
      bus_valid <= |grant;
      bus_out   <= (|grant) ? src[grant_sel] : '0;
    end
  end

endmodule
